// File: rtl/channel_mac_if.sv
// Bundles the per-channel FIFO read ports, row control and result handshake
// of the channel_mac block; the DUT uses the slave modport.
interface channel_mac_if #(
   parameter int channel_num = 4,
   parameter int val_bits    = 8,
   parameter int vec_bits    = 8,
   parameter int acc_bits    = 24,
   parameter int len_bits    = 8
);
   logic [channel_num-1:0]          start;
   logic [len_bits*channel_num-1:0] row_len;
   logic [val_bits*channel_num-1:0] val_in;
   logic [channel_num-1:0]          val_empty;
   logic [channel_num-1:0]          val_read;
   logic [vec_bits*channel_num-1:0] vec_in;
   logic [channel_num-1:0]          vec_empty;
   logic [channel_num-1:0]          vec_read;
   logic [acc_bits*channel_num-1:0] result;
   logic [channel_num-1:0]          result_valid;
   logic [channel_num-1:0]          result_ready;
   logic [channel_num-1:0]          busy;

   modport slave (
      input  start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
      output val_read, vec_read, result, result_valid, busy
   );

   modport master (
      output start, row_len, val_in, val_empty, vec_in, vec_empty, result_ready,
      input  val_read, vec_read, result, result_valid, busy
   );
endinterface

// File: rtl/channel_mac.sv
// Per-channel multiply-accumulate: pops value/vector pairs from standard FIFOs,
// accumulates a row of products and hands the dot product out on valid/ready.
module channel_mac #(
   parameter int channel_num = 4,
   parameter int val_bits    = 8,
   parameter int vec_bits    = 8,
   parameter int acc_bits    = 24,
   parameter int len_bits    = 8
) (
   input logic        clk,
   input logic        rst,
   channel_mac_if.slave bus
);
   localparam int prod_bits = val_bits + vec_bits;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   logic [channel_num-1:0]          rd_all;
   logic [channel_num-1:0]          busy_all;
   logic [channel_num-1:0]          valid_all;
   logic [acc_bits*channel_num-1:0] result_all;

   assign bus.val_read     = rd_all;
   assign bus.vec_read     = rd_all;
   assign bus.busy         = busy_all;
   assign bus.result_valid = valid_all;
   assign bus.result       = result_all;

   for (genvar i = 0; i < channel_num; i++) begin : g_ch
      state_t                state;
      state_t                next_state;
      logic [len_bits-1:0]   remaining;
      logic [len_bits-1:0]   len;
      logic [val_bits-1:0]   val;
      logic [vec_bits-1:0]   vec;
      logic [prod_bits-1:0]  prod;
      logic [acc_bits-1:0]   acc;
      logic [acc_bits-1:0]   res;
      logic                  rd_valid;
      logic                  prod_valid;
      logic                  res_valid;
      logic                  rd;
      logic                  load_res;
      logic                  begin_row;

      assign len = bus.row_len[i*len_bits +: len_bits];
      assign val = bus.val_in[i*val_bits +: val_bits];
      assign vec = bus.vec_in[i*vec_bits +: vec_bits];

      assign begin_row = (state == IDLE) && bus.start[i];

      assign rd_all[i]                       = rd;
      assign busy_all[i]                     = (state != IDLE);
      assign valid_all[i]                    = res_valid;
      assign result_all[i*acc_bits +: acc_bits] = res;

      always_ff @(posedge clk) begin
         if (rst) begin
            state <= IDLE;
         end else begin
            state <= next_state;
         end
      end

      // Reads issue only from ACCUM with both FIFOs non-empty; DRAIN releases
      // once the read stage is empty, folding the final product into the result.
      always_comb begin
         next_state = state;
         rd         = 1'b0;
         load_res   = 1'b0;
         case (state)
            IDLE: begin
               if (bus.start[i]) begin
                  next_state = (len == '0) ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               rd = (remaining != '0) && !bus.val_empty[i] && !bus.vec_empty[i];
               if (rd && (remaining == len_bits'(1))) begin
                  next_state = DRAIN;
               end
            end
            DRAIN: begin
               if (!rd_valid) begin
                  load_res   = 1'b1;
                  next_state = HOLD;
               end
            end
            HOLD: begin
               if (bus.result_ready[i]) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end

      // Two-stage datapath: FIFO dout lands one cycle after the read, the
      // product is registered, then added into the wrapping accumulator.
      always_ff @(posedge clk) begin
         if (rst) begin
            remaining  <= '0;
            prod       <= '0;
            acc        <= '0;
            res        <= '0;
            rd_valid   <= 1'b0;
            prod_valid <= 1'b0;
            res_valid  <= 1'b0;
         end else begin
            rd_valid   <= rd;
            prod_valid <= rd_valid;
            if (rd_valid) begin
               prod <= prod_bits'(val) * prod_bits'(vec);
            end
            if (begin_row) begin
               remaining <= len;
               acc       <= '0;
            end else begin
               if (rd) begin
                  remaining <= remaining - len_bits'(1);
               end
               if (prod_valid) begin
                  acc <= acc + acc_bits'(prod);
               end
            end
            if (load_res) begin
               res       <= prod_valid ? acc + acc_bits'(prod) : acc;
               res_valid <= 1'b1;
            end else if (begin_row && (len == '0)) begin
               res       <= '0;
               res_valid <= 1'b1;
            end else if ((state == HOLD) && bus.result_ready[i]) begin
               res_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_channel_mac.sv
// Self-checking bench for channel_mac: models the standard FIFOs per channel and
// scores row results against expected sums queued when each row is loaded.
module tb_channel_mac;
   localparam int CH = 4;
   localparam int VB = 8;
   localparam int WB = 8;
   localparam int AB = 16;
   localparam int LB = 8;

   logic clk = 1'b0;
   logic rst;

   channel_mac_if #(.channel_num(CH), .val_bits(VB), .vec_bits(WB),
                    .acc_bits(AB), .len_bits(LB)) bus ();

   channel_mac #(.channel_num(CH), .val_bits(VB), .vec_bits(WB),
                 .acc_bits(AB), .len_bits(LB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [VB*CH-1:0] val_dout    = '0;
   logic [WB*CH-1:0] vec_dout    = '0;
   logic [CH-1:0]    val_empty_q = '1;
   logic [CH-1:0]    vec_empty_q = '1;

   assign bus.val_in    = val_dout;
   assign bus.vec_in    = vec_dout;
   assign bus.val_empty = val_empty_q;
   assign bus.vec_empty = vec_empty_q;

   logic [VB-1:0] val_fifo [CH][$];
   logic [VB-1:0] val_new  [CH][$];
   logic [WB-1:0] vec_fifo [CH][$];
   logic [WB-1:0] vec_new  [CH][$];
   logic [AB-1:0] exp_q    [CH][$];

   int read_count [CH];
   int underflows  = 0;
   int pair_errors = 0;
   int checks      = 0;
   int failures    = 0;

   initial begin
      for (int i = 0; i < CH; i++) read_count[i] = 0;
   end

   // Standard FIFO model: dout updates the cycle after rd_en, pushes become visible a cycle later
   always @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (bus.val_read[i] !== bus.vec_read[i]) pair_errors++;
         if (bus.val_read[i] === 1'b1) begin
            read_count[i]++;
            if (val_fifo[i].size() > 0) val_dout[i*VB +: VB] <= val_fifo[i].pop_front();
            else underflows++;
         end
         if (bus.vec_read[i] === 1'b1) begin
            if (vec_fifo[i].size() > 0) vec_dout[i*WB +: WB] <= vec_fifo[i].pop_front();
            else underflows++;
         end
         while (val_new[i].size() > 0) val_fifo[i].push_back(val_new[i].pop_front());
         while (vec_new[i].size() > 0) vec_fifo[i].push_back(vec_new[i].pop_front());
         val_empty_q[i] <= (val_fifo[i].size() == 0);
         vec_empty_q[i] <= (vec_fifo[i].size() == 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_val(input int ch, input logic [VB-1:0] v);
      val_new[ch].push_back(v);
   endtask

   task automatic push_vec(input int ch, input logic [WB-1:0] w);
      vec_new[ch].push_back(w);
   endtask

   task automatic set_len(input int ch, input int len);
      bus.row_len[ch*LB +: LB] = LB'(len);
   endtask

   task automatic pulse_start(input logic [CH-1:0] mask);
      bus.start = mask;
      @(negedge clk);
      bus.start = '0;
   endtask

   task automatic flush_fifos(input int ch);
      val_fifo[ch].delete();
      vec_fifo[ch].delete();
   endtask

   function automatic logic [AB-1:0] mac_step(input logic [AB-1:0] acc,
                                              input logic [VB-1:0] v,
                                              input logic [WB-1:0] w);
      logic [VB+WB-1:0] p;
      p = {{WB{1'b0}}, v} * {{VB{1'b0}}, w};
      return acc + AB'(p);
   endfunction

   task automatic wait_result(input int ch, input int limit, output logic seen,
                              output logic [AB-1:0] value);
      seen  = 1'b0;
      value = '0;
      for (int c = 0; c < limit && !seen; c++) begin
         if (bus.result_valid[ch] === 1'b1) begin
            seen  = 1'b1;
            value = bus.result[ch*AB +: AB];
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++;
      if (bus.busy !== '0) begin
         failures++;
         $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
      end
      checks++;
      if (bus.result_valid !== '0) begin
         failures++;
         $display("[TB] FAIL reset_valid got=%b want=0", bus.result_valid);
      end
      checks++;
      if (bus.result !== '0) begin
         failures++;
         $display("[TB] FAIL reset_result got=%h want=0", bus.result);
      end
      checks++;
      if ((bus.val_read | bus.vec_read) !== '0) begin
         failures++;
         $display("[TB] FAIL reset_reads got=%b/%b want=0", bus.val_read, bus.vec_read);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_single_row;
      logic [VB-1:0] vals [3] = '{8'd2, 8'd3, 8'd4};
      logic [WB-1:0] vecs [3] = '{8'd5, 8'd6, 8'd7};
      logic [AB-1:0] sum = '0;
      logic [AB-1:0] got = '0;
      logic [AB-1:0] want;
      int first = -1, last = -1, vcyc = -1, n = 0;
      int r0 = read_count[0];
      for (int k = 0; k < 3; k++) begin
         push_val(0, vals[k]);
         push_vec(0, vecs[k]);
         sum = mac_step(sum, vals[k], vecs[k]);
      end
      exp_q[0].push_back(sum);
      idle(2);
      bus.result_ready[0] = 1'b1;
      set_len(0, 3);
      pulse_start(4'b0001);
      for (int c = 1; c <= 20; c++) begin
         if (bus.val_read[0] === 1'b1) begin
            if (first < 0) first = c;
            last = c;
            n++;
         end
         if (bus.result_valid[0] === 1'b1 && vcyc < 0) begin
            vcyc = c;
            got  = bus.result[0 +: AB];
         end
         @(negedge clk);
      end
      checks++;
      if (n !== 3) begin
         failures++;
         $display("[TB] FAIL single_read_pulses got=%0d want=3", n);
      end
      checks++;
      if (last - first !== 2) begin
         failures++;
         $display("[TB] FAIL single_consecutive span got=%0d want=2", last - first);
      end
      checks++;
      if (vcyc - last !== 3) begin
         failures++;
         $display("[TB] FAIL single_latency got=%0d want=3", vcyc - last);
      end
      checks++;
      if (vcyc < 0) begin
         failures++;
         $display("[TB] FAIL single_result timeout got=none want=%0d", sum);
      end else begin
         want = exp_q[0].pop_front();
         if (got !== want) begin
            failures++;
            $display("[TB] FAIL single_result got=%0d want=%0d", got, want);
         end
      end
      checks++;
      if (read_count[0] - r0 !== 3) begin
         failures++;
         $display("[TB] FAIL single_total_reads got=%0d want=3", read_count[0] - r0);
      end
      checks++;
      if (bus.busy[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_idle_after busy=%b want=0", bus.busy[0]);
      end
   endtask

   task automatic test_stall;
      logic [VB-1:0] vals [2] = '{8'd10, 8'd20};
      logic [WB-1:0] vecs [2] = '{8'd1, 8'd2};
      logic [AB-1:0] sum = '0;
      logic [AB-1:0] got, want;
      logic seen;
      int stray = 0, stall_busy = 0;
      int r1 = read_count[1];
      for (int k = 0; k < 2; k++) begin
         push_val(1, vals[k]);
         sum = mac_step(sum, vals[k], vecs[k]);
      end
      exp_q[1].push_back(sum);
      idle(2);
      set_len(1, 2);
      pulse_start(4'b0010);
      for (int c = 0; c < 5; c++) begin
         if ((bus.val_read[1] | bus.vec_read[1]) !== 1'b0) stray++;
         if (bus.busy[1] === 1'b1) stall_busy++;
         @(negedge clk);
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("[TB] FAIL stall_no_reads got=%0d want=0", stray);
      end
      checks++;
      if (stall_busy !== 5) begin
         failures++;
         $display("[TB] FAIL stall_busy cycles got=%0d want=5", stall_busy);
      end
      for (int k = 0; k < 2; k++) push_vec(1, vecs[k]);
      wait_result(1, 30, seen, got);
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL stall_result timeout got=none want=%0d", sum);
      end else begin
         want = exp_q[1].pop_front();
         if (got !== want) begin
            failures++;
            $display("[TB] FAIL stall_result got=%0d want=%0d", got, want);
         end
      end
      idle(3);
      checks++;
      if (read_count[1] - r1 !== 2) begin
         failures++;
         $display("[TB] FAIL stall_total_reads got=%0d want=2", read_count[1] - r1);
      end
   endtask

   task automatic test_backpressure;
      logic [AB-1:0] got, want;
      logic seen;
      int unstable = 0;
      int r2 = read_count[2];
      push_val(2, 8'd3);
      push_vec(2, 8'd4);
      push_val(2, 8'd9);
      push_vec(2, 8'd9);
      exp_q[2].push_back(mac_step('0, 8'd3, 8'd4));
      idle(2);
      bus.result_ready[2] = 1'b0;
      set_len(2, 1);
      pulse_start(4'b0100);
      wait_result(2, 20, seen, got);
      want = exp_q[2].pop_front();
      checks++;
      if (!seen || got !== want) begin
         failures++;
         $display("[TB] FAIL bp_result seen=%b got=%0d want=%0d", seen, got, want);
      end
      for (int c = 0; c < 4; c++) begin
         bus.start[2] = (c % 2 == 0);
         set_len(2, 5);
         @(negedge clk);
         if (bus.result_valid[2] !== 1'b1 || bus.result[2*AB +: AB] !== want) unstable++;
      end
      checks++;
      if (unstable !== 0) begin
         failures++;
         $display("[TB] FAIL bp_hold_stable unstable_cycles got=%0d want=0", unstable);
      end
      bus.result_ready[2] = 1'b1;
      bus.start[2]        = 1'b1;
      @(negedge clk);
      bus.start[2]        = 1'b0;
      checks++;
      if (bus.result_valid[2] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_valid_clear got=%b want=0", bus.result_valid[2]);
      end
      checks++;
      if (bus.busy[2] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_idle_after busy=%b want=0", bus.busy[2]);
      end
      checks++;
      if (bus.result[2*AB +: AB] !== want) begin
         failures++;
         $display("[TB] FAIL bp_result_kept got=%0d want=%0d", bus.result[2*AB +: AB], want);
      end
      idle(3);
      checks++;
      if (read_count[2] - r2 !== 1) begin
         failures++;
         $display("[TB] FAIL bp_total_reads got=%0d want=1", read_count[2] - r2);
      end
      flush_fifos(2);
      idle(2);
   endtask

   task automatic test_wrap_zero;
      logic [AB-1:0] sum = '0;
      logic [AB-1:0] got, want;
      logic seen;
      int r3;
      for (int k = 0; k < 2; k++) begin
         push_val(3, 8'd255);
         push_vec(3, 8'd255);
         sum = mac_step(sum, 8'd255, 8'd255);
      end
      exp_q[3].push_back(sum);
      idle(2);
      bus.result_ready[3] = 1'b1;
      set_len(3, 2);
      pulse_start(4'b1000);
      wait_result(3, 20, seen, got);
      want = exp_q[3].pop_front();
      checks++;
      if (!seen || got !== want || got !== 16'd64514) begin
         failures++;
         $display("[TB] FAIL wrap_result seen=%b got=%0d want=%0d", seen, got, want);
      end
      idle(2);
      r3 = read_count[3];
      exp_q[3].push_back('0);
      bus.result_ready[3] = 1'b0;
      set_len(3, 0);
      pulse_start(4'b1000);
      want = exp_q[3].pop_front();
      checks++;
      if (bus.result_valid[3] !== 1'b1 || bus.result[3*AB +: AB] !== want) begin
         failures++;
         $display("[TB] FAIL zero_len valid=%b got=%0d want=%0d", bus.result_valid[3],
                  bus.result[3*AB +: AB], want);
      end
      bus.result_ready[3] = 1'b1;
      idle(1);
      checks++;
      if (bus.result_valid[3] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_len_clear got=%b want=0", bus.result_valid[3]);
      end
      checks++;
      if (read_count[3] - r3 !== 0) begin
         failures++;
         $display("[TB] FAIL zero_len_reads got=%0d want=0", read_count[3] - r3);
      end
   endtask

   task automatic test_parallel_reset;
      logic [AB-1:0] sum;
      logic [AB-1:0] got [CH];
      logic          seen [CH];
      logic [VB-1:0] v;
      logic [WB-1:0] w;
      logic [AB-1:0] want;
      int            r [CH];
      bus.result_ready = '1;
      for (int ch = 0; ch < CH; ch++) begin
         for (int k = 0; k < 4; k++) begin
            push_val(ch, VB'($urandom_range(255, 1)));
            push_vec(ch, WB'($urandom_range(255, 1)));
         end
         set_len(ch, 4);
      end
      idle(2);
      pulse_start('1);
      idle(1);
      rst = 1'b1;
      idle(1);
      checks++;
      if (bus.busy !== '0 || bus.result_valid !== '0 || bus.result !== '0) begin
         failures++;
         $display("[TB] FAIL par_reset_outputs busy=%b valid=%b result=%h want=0",
                  bus.busy, bus.result_valid, bus.result);
      end
      checks++;
      if ((bus.val_read | bus.vec_read) !== '0) begin
         failures++;
         $display("[TB] FAIL par_reset_reads got=%b want=0", bus.val_read | bus.vec_read);
      end
      rst = 1'b0;
      for (int ch = 0; ch < CH; ch++) flush_fifos(ch);
      idle(2);
      for (int ch = 0; ch < CH; ch++) begin
         sum = '0;
         for (int k = 0; k < 2 + ch; k++) begin
            v = VB'($urandom_range(255, 0));
            w = WB'($urandom_range(255, 0));
            push_val(ch, v);
            push_vec(ch, w);
            sum = mac_step(sum, v, w);
         end
         exp_q[ch].push_back(sum);
         set_len(ch, 2 + ch);
         r[ch]    = read_count[ch];
         seen[ch] = 1'b0;
         got[ch]  = '0;
      end
      idle(2);
      pulse_start('1);
      for (int c = 0; c < 40; c++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if (bus.result_valid[ch] === 1'b1 && !seen[ch]) begin
               seen[ch] = 1'b1;
               got[ch]  = bus.result[ch*AB +: AB];
            end
         end
         @(negedge clk);
      end
      for (int ch = 0; ch < CH; ch++) begin
         want = exp_q[ch].pop_front();
         checks++;
         if (!seen[ch] || got[ch] !== want) begin
            failures++;
            $display("[TB] FAIL par_result ch=%0d seen=%b got=%0d want=%0d", ch, seen[ch],
                     got[ch], want);
         end
         checks++;
         if (read_count[ch] - r[ch] !== 2 + ch) begin
            failures++;
            $display("[TB] FAIL par_reads ch=%0d got=%0d want=%0d", ch,
                     read_count[ch] - r[ch], 2 + ch);
         end
      end
   endtask

   task automatic test_fifo_protocol;
      checks++;
      if (underflows !== 0) begin
         failures++;
         $display("[TB] FAIL fifo_underflow got=%0d want=0", underflows);
      end
      checks++;
      if (pair_errors !== 0) begin
         failures++;
         $display("[TB] FAIL read_pairing got=%0d want=0", pair_errors);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst              = 1'b1;
      bus.start        = '0;
      bus.row_len      = '0;
      bus.result_ready = '1;
      @(negedge clk);
      test_reset();
      test_single_row();
      test_stall();
      test_backpressure();
      test_wrap_zero();
      test_parallel_reset();
      test_fifo_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/channel_mac.md
Name: channel_mac

Overview:
- Per-channel multiply-accumulate stage directly downstream of the value fetcher's per-channel value FIFOs.
- Each channel pops one matrix value and one matching vector operand from two standard (non-FWFT) FIFOs per element.
- It multiplies the pair and accumulates the products over a row of configurable length.
- At row end it presents the dot product on a valid/ready result port.
- All channels run independently, in parallel, in one clock domain.

Parameters:
- channel_num, 4, number of independent channels.
- val_bits, 8, matrix value width, unsigned.
- vec_bits, 8, vector operand width, unsigned.
- acc_bits, 24, accumulator/result width; must be >= val_bits+vec_bits.
- len_bits, 8, row length counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  channel_num  per-channel start pulse; begins a row.
- row_len  in  len_bits*channel_num  per-channel element count, sampled on start.
- val_in  in  val_bits*channel_num  value FIFO dout.
- val_empty  in  channel_num  value FIFO empty.
- val_read  out  channel_num  value FIFO rd_en.
- vec_in  in  vec_bits*channel_num  vector FIFO dout.
- vec_empty  in  channel_num  vector FIFO empty.
- vec_read  out  channel_num  vector FIFO rd_en.
- result  out  acc_bits*channel_num  completed row sum.
- result_valid  out  channel_num  result held valid until accepted.
- result_ready  in  channel_num  consumer accept.
- busy  out  channel_num  high whenever the channel is not IDLE.

Behaviour:
- Reset (synchronous, rst high at posedge): every channel goes to IDLE. val_read=0, vec_read=0, result=0, result_valid=0, busy=0, accumulator=0, counters=0, pipeline valid bits=0. Reset mid-row abandons the row. FIFO contents are untouched.
- FIFO read latency: dout is valid the cycle after rd_en was asserted.
- Per-channel FSM states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE:
  - start=1 latches row_len into a remaining counter, clears the accumulator, and moves to ACCUM.
  - If the latched row_len=0, the channel goes directly to HOLD with result=0 one cycle after start.
- ACCUM:
  - val_read=vec_read=1 (same cycle, always together) iff remaining!=0 && !val_empty && !vec_empty. Both reads are combinational from the current state and counter.
  - Each issued read decrements remaining.
  - Cycle t+1 after a read: product = val_in*vec_in (full val_bits+vec_bits, zero-extended) is registered.
  - Cycle t+2: accumulator += product, modulo 2^acc_bits (wrap, no saturation).
  - Sustained throughput: one element per cycle while both FIFOs are non-empty.
  - When the last read issues (remaining goes 1->0), move to DRAIN.
- DRAIN: wait until both pipeline stages are empty (2 cycles after the last read), then load result from the accumulator, set result_valid=1, and go to HOLD.
  - Latency from the last read to result_valid: 3 cycles.
- HOLD: result and result_valid are stable. When result_ready=1, drop result_valid next cycle and go to IDLE. result keeps its last value after the handshake.
- start while not IDLE: ignored, with no effect on the row in progress. start in the same cycle as a HOLD handshake: ignored; the channel returns to IDLE first.
- One FIFO empty and the other non-empty: no read from either; the channel stalls with no progress and no error.
- Channels never interact; simultaneous activity on all channels is required to work.
- No reads are ever issued outside ACCUM or beyond row_len.

Test Plan:
- Single row: ch0 row_len=3, vals {2,3,4}, vecs {5,6,7} preloaded, result_ready=1 -> exactly 3 val_read/vec_read pulses on consecutive cycles; result_valid 3 cycles after the last read; result=56.
- Stall/imbalance: ch1 row_len=2, vector FIFO empty for 5 cycles while value FIFO holds {10,20} -> no reads during the gap; vecs {1,2} then arrive -> result=50; no extra reads.
- Backpressure: result_ready=0 for 4 cycles in HOLD -> result_valid and result stable; start pulses during this time are ignored; ready=1 -> valid clears next cycle, state IDLE.
- Wrap and zero length: acc_bits=16, row_len=2, vals {255,255}, vecs {255,255} -> result=(2*65025) mod 65536=64514. row_len=0 -> result=0, valid one cycle after start, no reads.
- Parallel plus reset: all 4 channels start with different rows; rst asserted mid-row on cycle 2 -> all outputs 0 next cycle, no reads. A restart afterwards completes correctly from fresh FIFO data.
